ptp_ram_reader: RTL

PTP_RAM_READER -- requirements
Module: ptp_ram_reader

---
 rtl/ptp_ram_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ptp_ram_reader.sv
// rtl/ptp_ram_reader.sv - credit-paced RAM frame reader feeding a valid/ready word stream
// Reads are only issued when the skid FIFO is guaranteed room for every word still in flight.
module ptp_ram_reader #(
   parameter int RD_LAT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  start_addr,
   input  logic [9:0]  len_words,
   output logic        busy,
   output logic        done,
   output logic [8:0]  ram_address,
   output logic        ram_wren,
   output logic [3:0]  ram_byteena,
   output logic [31:0] ram_data,
   input  logic [31:0] ram_q,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop
);

   localparam int DEPTH = RD_LAT + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [8:0]        addr_q, addr_d;
   logic [9:0]        len_q, len_d;
   logic [9:0]        left_q, left_d;
   logic [9:0]        idx_q, idx_d;
   logic [RD_LAT-1:0] vsr_q, vsr_d;
   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];
   logic [1:0]        wr_q, wr_d;
   logic [1:0]        rd_q, rd_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              zero_done_q, zero_done_d;

   logic              accept;
   logic              issue_en;
   logic              issue;
   logic              pop;
   logic              land;
   logic [2:0]        inflight;
   logic [3:0]        used;

   assign ram_wren    = 1'b0;
   assign ram_byteena = 4'hF;
   assign ram_data    = 32'd0;

   assign busy      = (state_q != IDLE);
   assign out_valid = (cnt_q != 3'd0);
   assign out_data  = mem_q[rd_q];
   assign out_sop   = out_valid && (idx_q == 10'd0);
   assign out_eop   = out_valid && (idx_q == len_q - 10'd1);
   assign done      = zero_done_q || ((state_q == DRAIN) && pop && out_eop);

   assign accept = (state_q == IDLE) && start && (len_words != 10'd0);
   assign pop    = out_valid && out_ready;
   assign land   = vsr_q[RD_LAT-1];

   // The first read goes out in the start cycle itself so data returns one cycle earlier.
   assign ram_address = (accept && !reset) ? start_addr : addr_q;

   always_comb begin
      inflight = 3'd0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + 3'(vsr_q[i]);
      end
      // Occupancy after this cycle's pop plus all outstanding reads must leave a free slot.
      used     = 4'(cnt_q) + 4'(inflight) - {3'd0, pop};
      issue_en = (state_q == ISSUE) && (used < 4'(DEPTH));
      issue    = accept || issue_en;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      left_d      = left_q;
      idx_d       = idx_q;
      zero_done_d = 1'b0;
      mem_d       = mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q + {2'd0, land} - {2'd0, pop};
      vsr_d       = RD_LAT'({vsr_q, issue});

      if (land) begin
         mem_d[wr_q] = ram_q;
         wr_d        = (wr_q == 2'(DEPTH - 1)) ? 2'd0 : wr_q + 2'd1;
      end
      if (pop) begin
         rd_d  = (rd_q == 2'(DEPTH - 1)) ? 2'd0 : rd_q + 2'd1;
         idx_d = idx_q + 10'd1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = start_addr + 9'd1;
               len_d   = len_words;
               left_d  = len_words - 10'd1;
               idx_d   = 10'd0;
               state_d = (len_words == 10'd1) ? DRAIN : ISSUE;
            end else if (start) begin
               zero_done_d = 1'b1;
            end
         end
         ISSUE: begin
            if (issue_en) begin
               addr_d = addr_q + 9'd1;
               left_d = left_q - 10'd1;
               if (left_q == 10'd1) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && out_eop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= 9'd0;
         len_q       <= 10'd0;
         left_q      <= 10'd0;
         idx_q       <= 10'd0;
         vsr_q       <= '0;
         wr_q        <= 2'd0;
         rd_q        <= 2'd0;
         cnt_q       <= 3'd0;
         zero_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         left_q      <= left_d;
         idx_q       <= idx_d;
         vsr_q       <= vsr_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         zero_done_q <= zero_done_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
